// File: rtl/i2c_reg_responder.sv
// rtl/i2c_reg_responder.sv - byte register bank answering I2C sequencer read/write transactions
// Optional read-only status byte at DEPTH-1 when I2C_RESP_STATUS_REG_EN is defined.
module i2c_reg_responder #(
    parameter int         DEPTH       = 16,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_i2c_op,
    input  logic [10:0] i_i2c_addr,
    input  logic [7:0]  i_i2c_data,
    input  logic        i_i2c_xfc,
    input  logic        i_rd_next,
    input  logic        i_stop_out,
    output logic [7:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_busy,
    output logic        o_addr_err,
    output logic [7:0]  o_ctrl_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_regs [DEPTH];
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   r_wr_idx;
    logic [7:0]      r_wr_data;
    logic            r_oor;
    logic [7:0]      r_rd_data;
    logic            r_rd_valid;
    logic            r_busy;
    logic            r_addr_err;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;
    logic [7:0]      w_rd_byte;
    logic            w_wr_allowed;
`ifdef I2C_RESP_STATUS_REG_EN
    logic [3:0]      r_wr_count;
`endif

    assign w_in_range = (i_i2c_addr < 11'(DEPTH));
    assign w_idx      = i_i2c_addr[AW-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_i2c_xfc)      w_next = i_i2c_op ? S_WR : S_RD;
                else if (i_rd_next) w_next = S_RD;
            end
            S_WR:    w_next = S_IDLE;
            S_RD:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_stop_out) w_next = S_IDLE;
    end

    // Status byte shadows the top register when the status feature is built in.
    always_comb begin
        w_rd_byte    = r_regs[r_ptr];
        w_wr_allowed = 1'b1;
`ifdef I2C_RESP_STATUS_REG_EN
        if (r_ptr == AW'(DEPTH-1))    w_rd_byte    = {r_addr_err, 3'b000, r_wr_count};
        if (r_wr_idx == AW'(DEPTH-1)) w_wr_allowed = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= RESET_VALUE;
            r_ptr      <= '0;
            r_wr_idx   <= '0;
            r_wr_data  <= 8'h00;
            r_oor      <= 1'b0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
`ifdef I2C_RESP_STATUS_REG_EN
            r_wr_count <= 4'h0;
`endif
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);
            r_rd_valid <= 1'b0;
            if (i_stop_out) begin
                r_ptr      <= '0;
                r_addr_err <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_i2c_xfc) begin
                            r_oor <= !w_in_range;
                            if (i_i2c_op) begin
                                r_wr_idx  <= w_idx;
                                r_wr_data <= i_i2c_data;
                            end else begin
                                r_ptr <= w_idx;
                            end
                        end else if (i_rd_next) begin
                            r_ptr <= r_ptr + AW'(1);
                            r_oor <= 1'b0;
                        end
                    end
                    S_WR: begin
                        if (r_oor) begin
                            r_addr_err <= 1'b1;
                        end else if (w_wr_allowed) begin
                            r_regs[r_wr_idx] <= r_wr_data;
`ifdef I2C_RESP_STATUS_REG_EN
                            r_wr_count <= r_wr_count + 4'h1;
`endif
                        end
                    end
                    S_RD: begin
                        r_rd_data  <= r_oor ? 8'hFF : w_rd_byte;
                        r_rd_valid <= 1'b1;
                        if (r_oor) r_addr_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_busy     = r_busy;
    assign o_addr_err = r_addr_err;
    assign o_ctrl_out = r_regs[0];
endmodule
